// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem request, IF/ID register, HLT handling
//
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   stall           decode hazard: hold PC and IF/ID
//   redirect_valid  taken branch/JAL/JR from downstream (beats stall)
//   redirect_pc     redirect target
//   imem_re         instruction memory read request (RUN only, low in reset)
//   imem_addr       request word address (= pc)
//   imem_rdy        imem_data valid this cycle
//   imem_data       instruction word from memory
//   if_id_instr     registered instruction (0 when bubble)
//   if_id_pc_plus1  registered PC+1 of that instruction
//   if_id_valid     IF/ID holds a real instruction
//   opcode          if_id_instr[15:12] to the decoder
//   halted          fetch stopped on HLT
//   perf_fetch_cnt  (FETCH_PERF_EN) saturating capture count
//   perf_bubble_cnt (FETCH_PERF_EN) saturating bubble-insertion count
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OP   = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_re,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic [3:0]  opcode,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_bubble_cnt
`endif
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state, next_state;
    logic [15:0] pc, pc_n;
    logic [15:0] instr_n, pcp1_n;
    logic        valid_n, halted_n;
    logic [15:0] pc_inc;

    assign pc_inc    = pc + 16'd1;   // wraps 16'hFFFF -> 16'h0000
    assign imem_addr = pc;
    // Gate with rst so an outstanding request is dropped the moment reset rises.
    assign imem_re   = (state == RUN) && !rst;
    assign opcode    = if_id_instr[15:12];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_instr    <= 16'h0000;
            if_id_pc_plus1 <= 16'h0000;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= next_state;
            pc             <= pc_n;
            if_id_instr    <= instr_n;
            if_id_pc_plus1 <= pcp1_n;
            if_id_valid    <= valid_n;
            halted         <= halted_n;
        end
    end

    always_comb begin
        next_state = state;
        pc_n       = pc;
        instr_n    = if_id_instr;
        pcp1_n     = if_id_pc_plus1;
        valid_n    = if_id_valid;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    // Flush; whatever memory returned this cycle is wrong-path.
                    pc_n    = redirect_pc;
                    instr_n = 16'h0000;
                    valid_n = 1'b0;
                end else if (stall) begin
                    // Hold everything; same address is re-requested next cycle.
                end else if (imem_rdy) begin
                    instr_n = imem_data;
                    pcp1_n  = pc_inc;
                    valid_n = 1'b1;
                    pc_n    = pc_inc;
                    if (imem_data[15:12] == HLT_OP)
                        next_state = HALT;
                end else begin
                    instr_n = 16'h0000;
                    valid_n = 1'b0;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    // HLT was speculative behind a taken branch.
                    pc_n       = redirect_pc;
                    next_state = RUN;
                    instr_n    = 16'h0000;
                    valid_n    = 1'b0;
                end else if (!stall) begin
                    // HLT word drains out of IF/ID once decode accepts it.
                    instr_n = 16'h0000;
                    valid_n = 1'b0;
                end
            end
            default: next_state = RUN;
        endcase
        halted_n = (next_state == HALT);
    end

`ifdef FETCH_PERF_EN
    logic fetch_inc, bubble_inc;

    assign fetch_inc  = (state == RUN) && !redirect_valid && !stall && imem_rdy;
    assign bubble_inc = (state == RUN) && (redirect_valid || (!stall && !imem_rdy));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt  <= 16'h0000;
            perf_bubble_cnt <= 16'h0000;
        end else begin
            if (fetch_inc && perf_fetch_cnt != 16'hFFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if (bubble_inc && perf_bubble_cnt != 16'hFFFF)
                perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
        end
    end
`else
    // Counters not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_re;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic [3:0]  opcode;
    logic        halted;

    int tests = 0;
    int fails = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_re        (imem_re),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .opcode         (opcode),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] instr,
                              input logic [15:0] pcp1, input logic valid,
                              input logic [15:0] addr);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pcp1"},  if_id_pc_plus1, pcp1);
        check({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, valid});
        check({tag, ".addr"},  imem_addr, addr);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.re", {15'd0, imem_re}, 16'd0);
        check("rst.halted", {15'd0, halted}, 16'd0);
        check_ifid("rst", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step();
        rst = 1'b0;
        #1;
        check("run.re", {15'd0, imem_re}, 16'd1);

        // Zero-wait fetch from pc 0
        imem_rdy = 1'b1;
        imem_data = 16'h1234; step(); check_ifid("zw0", 16'h1234, 16'h0001, 1'b1, 16'h0001);
        check("zw0.opcode", {12'd0, opcode}, 16'h0001);
        imem_data = 16'h2345; step(); check_ifid("zw1", 16'h2345, 16'h0002, 1'b1, 16'h0002);
        imem_data = 16'h3456; step(); check_ifid("zw2", 16'h3456, 16'h0003, 1'b1, 16'h0003);
        imem_data = 16'h0001; step();
        imem_data = 16'h0002; step(); check_ifid("to5", 16'h0002, 16'h0005, 1'b1, 16'h0005);

        // Memory wait at pc 5
        imem_rdy = 1'b0;
        step(); check_ifid("wait0", 16'h0000, 16'h0005, 1'b0, 16'h0005);
        step(); check_ifid("wait1", 16'h0000, 16'h0005, 1'b0, 16'h0005);
        imem_rdy = 1'b1; imem_data = 16'h4567;
        step(); check_ifid("wait_done", 16'h4567, 16'h0006, 1'b1, 16'h0006);

        // Stall with memory ready: nothing moves
        stall = 1'b1; imem_data = 16'h5678;
        step(); check_ifid("stall0", 16'h4567, 16'h0006, 1'b1, 16'h0006);
        step(); check_ifid("stall1", 16'h4567, 16'h0006, 1'b1, 16'h0006);
        step(); check_ifid("stall2", 16'h4567, 16'h0006, 1'b1, 16'h0006);
        stall = 1'b0;
        step(); check_ifid("unstall", 16'h5678, 16'h0007, 1'b1, 16'h0007);

        // Stall and redirect together: redirect wins
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step();
        check("redir.instr", if_id_instr, 16'h0000);
        check("redir.valid", {15'd0, if_id_valid}, 16'd0);
        check("redir.addr", imem_addr, 16'h0040);
        // Back to pc 7 for the HLT case
        stall = 1'b0; redirect_pc = 16'h0007;
        step(); check("redir7.addr", imem_addr, 16'h0007);
        redirect_valid = 1'b0;

        // HLT at pc 7
        imem_data = 16'hF000;
        step(); check_ifid("hlt", 16'hF000, 16'h0008, 1'b1, 16'h0008);
        check("hlt.opcode", {12'd0, opcode}, 16'h000F);
        check("hlt.halted", {15'd0, halted}, 16'd1);
        check("hlt.re", {15'd0, imem_re}, 16'd0);
        imem_data = 16'h1111;
        step(); check_ifid("halt_drain", 16'h0000, 16'h0008, 1'b0, 16'h0008);
        check("halt_drain.halted", {15'd0, halted}, 16'd1);
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect_valid = 1'b0;
        check("resume.addr", imem_addr, 16'h0010);
        check("resume.halted", {15'd0, halted}, 16'd0);
        check("resume.re", {15'd0, imem_re}, 16'd1);
        check("resume.valid", {15'd0, if_id_valid}, 16'd0);

        // PC wrap at 0xFFFF
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect_valid = 1'b0; imem_data = 16'h2222;
        step(); check_ifid("wrap", 16'h2222, 16'h0000, 1'b1, 16'h0000);
        imem_data = 16'h3333;
        step(); check_ifid("post_wrap", 16'h3333, 16'h0001, 1'b1, 16'h0001);

        // Reset asserted mid-wait, between edges
        imem_rdy = 1'b0;
        step(); check_ifid("pre_rst", 16'h0000, 16'h0001, 1'b0, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check_ifid("async_rst", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        check("async_rst.re", {15'd0, imem_re}, 16'd0);
        check("async_rst.halted", {15'd0, halted}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
